fb_pixel_writer: RTL
====================

# fb_pixel_writer

Write-side engine for the 800x480 monochrome frame buffer. Accepts a raster-ordered 1-bit pixel stream over a valid/ready handshake, packs 16 pixels per word, and drives the frame buffer's write port (write_address, data_in, load). Also provides a clear command that fills every word with a constant, so software or a test-pattern generator never has to compute RAM addresses.

## Interface
- H_PIXELS, 800: active pixels per line; must be a multiple of 16.
- V_PIXELS, 480: active lines per frame.
- WORDS, derived localparam: H_PIXELS*V_PIXELS/16, 24000 at defaults.

- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a streamed frame at pixel 0.
- clear  in  1  single-cycle pulse; begins a full-buffer fill.
- fill_value  in  1  fill colour; sampled on the cycle clear is accepted.
- pix_valid  in  1  pixel stream valid.
- pix_data  in  1  pixel value; 1 = white, 0 = black.
- pix_ready  out  1  high when a pixel can be accepted.
- write_address  out  16  frame-buffer word address.
- data_in  out  16  frame-buffer write data.
- load  out  1  frame-buffer write enable; one word per cycle it is high.
- busy  out  1  high in STREAM or CLEAR.
- frame_done  out  1  single-cycle pulse on the cycle the final word is written.

## Operation
- Pixel mapping: linear index p = h + v*H_PIXELS; word p>>4, bit p[3:0]. Bit 0 holds the leftmost pixel of the word.
- States: IDLE, STREAM, CLEAR.
- IDLE: pix_ready=0, load=0. clear -> CLEAR, latch fill_value, word counter=0. Otherwise start -> STREAM, pixel counter=0. Both asserted together: clear wins, start dropped.
- STREAM: pix_ready=1. Pixel accepted when pix_valid & pix_ready; written into shift/assembly register at bit p[3:0]; p increments. On acceptance of bit 15, the assembled word and address p>>4 are registered onto data_in/write_address with load=1 next cycle. Acceptance of pixel WORDS*16-1 -> IDLE; frame_done=1 with that last load.
- CLEAR: one word per cycle, address 0..WORDS-1, data_in = 16 copies of latched fill_value, load=1 every cycle. Last word -> IDLE with frame_done=1.
- start/clear while busy: ignored. pix_valid outside STREAM: ignored, no side effects.
- Stream stalls (pix_valid low) hold p and the partial word indefinitely; no timeout.
- Widths: pixel counter 19 bits (max 383999); word counter 15 bits zero-extended to 16 on write_address. No wrap: counters never exceed WORDS*16-1 / WORDS-1; state exit precedes wrap.
- Reset mid-operation: -> IDLE next edge, partial word discarded, no further load.

## Timing
- Reset values: pix_ready 0, write_address 0, data_in 0, load 0, busy 0, frame_done 0; state IDLE, counters 0.
- start/clear sampled at edge N -> busy=1 from N+1; pix_ready=1 from N+1 (STREAM).
- First CLEAR load at N+1, last at N+WORDS (24000 cycles), frame_done at N+WORDS, busy=0 at N+WORDS+1.
- STREAM: 16th pixel of a word accepted at edge M -> load=1 for exactly cycle M+1. Throughput 1 pixel/cycle; load is never high two consecutive cycles in STREAM.
- pix_ready deasserts the cycle after the final pixel is accepted; the final pixel's handshake completes normally.
- All outputs registered; no combinational path from inputs to outputs except none (pix_ready is state-decoded from a register).

## Structure
- Shared package: H_PIXELS/V_PIXELS defaults, WORDS, state encoding (IDLE/STREAM/CLEAR), frame-buffer address/data widths (16/16) — reused by frame_buffer and VGA timing.
- One natural sub-module: fb_word_packer (16-bit assembly register + bit index, emits word_valid); FSM and address counters stay in the top.

## Test plan
- Reset: hold reset 3 cycles mid-CLEAR -> load=0 from next edge, busy=0, all outputs 0, no frame_done.
- CLEAR with fill_value=1 -> 24000 consecutive loads, addresses 0..23999, data 16'hFFFF, frame_done on address 23999 only.
- STREAM 16 pixels pattern 1,0,0,...,0,1 continuously -> one load, address 0, data 16'h8001, one cycle after 16th acceptance.
- STREAM full frame with random pix_valid gaps, pixel = (h==v) -> model compare all 24000 words; word at line 1 first word (address 50) = 16'h0002; frame_done once.
- start and clear same IDLE cycle -> CLEAR entered, pix_ready stays 0; start during STREAM -> pixel counter unaffected.
- pix_valid=1 in IDLE for 10 cycles, then start -> first accepted pixel lands at bit 0 of address 0.

Source files
------------

// File: rtl/fb_pixel_writer_pkg.sv
// Shared frame-buffer constants and types for the 800x480 monochrome display path.
// Used by the pixel writer, the frame buffer and the VGA timing blocks.
package fb_pixel_writer_pkg;

  localparam int unsigned FB_H_PIXELS    = 800;
  localparam int unsigned FB_V_PIXELS    = 480;
  localparam int unsigned FB_PIX_PER_WORD = 16;
  localparam int unsigned FB_WORDS       = FB_H_PIXELS * FB_V_PIXELS / FB_PIX_PER_WORD;

  localparam int unsigned FB_ADDR_W  = 16;
  localparam int unsigned FB_DATA_W  = 16;
  localparam int unsigned PIX_CNT_W  = 19;
  localparam int unsigned WORD_CNT_W = 15;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [FB_DATA_W-1:0] fb_data_t;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StClear
  } wr_state_e;

endpackage

// File: rtl/fb_pixel_writer_if.sv
// Pixel-stream, command and frame-buffer write-port signals of the pixel writer.
interface fb_pixel_writer_if;
  import fb_pixel_writer_pkg::*;

  logic     start;
  logic     clear;
  logic     fill_value;
  logic     pix_valid;
  logic     pix_data;
  logic     pix_ready;
  fb_addr_t write_address;
  fb_data_t data_in;
  logic     load;
  logic     busy;
  logic     frame_done;

  modport master (
    output start, clear, fill_value, pix_valid, pix_data,
    input  pix_ready, write_address, data_in, load, busy, frame_done
  );

  modport slave (
    input  start, clear, fill_value, pix_valid, pix_data,
    output pix_ready, write_address, data_in, load, busy, frame_done
  );

endinterface

// File: rtl/fb_word_packer.sv
// Assembles 16 accepted pixels into one word, leftmost pixel in bit 0.
// word_o already includes the pixel being accepted so the caller can register it directly.
module fb_word_packer
  import fb_pixel_writer_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     flush_i,
  input  logic     valid_i,
  input  logic     bit_i,
  output logic     word_valid_o,
  output fb_data_t word_o
);

  logic [3:0] idx_q;
  fb_data_t   asm_q;
  fb_data_t   asm_d;

  always_comb begin
    asm_d        = asm_q;
    asm_d[idx_q] = bit_i;
  end

  assign word_o       = asm_d;
  assign word_valid_o = valid_i && (idx_q == 4'd15);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      idx_q <= '0;
      asm_q <= '0;
    end else if (valid_i) begin
      idx_q <= idx_q + 4'd1;
      asm_q <= word_valid_o ? '0 : asm_d;
    end
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Write-side engine for the monochrome frame buffer: packs a raster pixel stream into words
// or fills the whole buffer with a constant, driving the frame buffer's write port.
module fb_pixel_writer
  import fb_pixel_writer_pkg::*;
#(
  parameter int unsigned H_PIXELS = FB_H_PIXELS,
  parameter int unsigned V_PIXELS = FB_V_PIXELS
) (
  input logic               clk,
  input logic               reset,
  fb_pixel_writer_if.slave  bus
);

  localparam int unsigned WORDS = H_PIXELS * V_PIXELS / FB_PIX_PER_WORD;
  localparam logic [PIX_CNT_W-1:0]  LastPix  = PIX_CNT_W'(WORDS * FB_PIX_PER_WORD - 1);
  localparam logic [WORD_CNT_W-1:0] LastWord = WORD_CNT_W'(WORDS - 1);

  wr_state_e             state_q, state_d;
  logic [PIX_CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic                  fill_q, fill_d;
  fb_addr_t              addr_q, addr_d;
  fb_data_t              data_q, data_d;
  logic                  load_q, load_d;
  logic                  done_q, done_d;

  logic     accept;
  logic     pk_flush;
  logic     pk_word_valid;
  fb_data_t pk_word;

  assign accept = (state_q == StStream) && bus.pix_valid;

  fb_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (pk_flush),
    .valid_i      (accept),
    .bit_i        (bus.pix_data),
    .word_valid_o (pk_word_valid),
    .word_o       (pk_word)
  );

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    word_cnt_d = word_cnt_q;
    fill_d     = fill_q;
    addr_d     = addr_q;
    data_d     = data_q;
    load_d     = 1'b0;
    done_d     = 1'b0;
    pk_flush   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // clear has priority; the first fill word goes out with the state change
        if (bus.clear) begin
          state_d    = StClear;
          fill_d     = bus.fill_value;
          word_cnt_d = '0;
          addr_d     = '0;
          data_d     = {FB_DATA_W{bus.fill_value}};
          load_d     = 1'b1;
          done_d     = (LastWord == '0);
        end else if (bus.start) begin
          state_d   = StStream;
          pix_cnt_d = '0;
          pk_flush  = 1'b1;
        end
      end

      StStream: begin
        if (accept) begin
          if (pk_word_valid) begin
            addr_d = FB_ADDR_W'(pix_cnt_q[PIX_CNT_W-1:4]);
            data_d = pk_word;
            load_d = 1'b1;
          end
          if (pix_cnt_q == LastPix) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
          end
        end
      end

      StClear: begin
        if (word_cnt_q == LastWord) begin
          state_d = StIdle;
        end else begin
          word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
          addr_d     = FB_ADDR_W'(word_cnt_d);
          data_d     = {FB_DATA_W{fill_q}};
          load_d     = 1'b1;
          done_d     = (word_cnt_d == LastWord);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pix_cnt_q  <= '0;
      word_cnt_q <= '0;
      fill_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      word_cnt_q <= word_cnt_d;
      fill_q     <= fill_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      load_q     <= load_d;
      done_q     <= done_d;
    end
  end

  assign bus.pix_ready     = (state_q == StStream);
  assign bus.busy          = (state_q != StIdle);
  assign bus.write_address = addr_q;
  assign bus.data_in       = data_q;
  assign bus.load          = load_q;
  assign bus.frame_done    = done_q;

endmodule
